md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  sync active-high reset (reset reset, synchronous, active-high; clock clk).
REQ-002 SHALL have e_valid  in  1  E-stage instruction valid; e_flush  in  1  E-stage instruction cancelled this cycle.
REQ-003 SHALL have e_mdop  in  4  0=NONE,1=MULT,2=MULTU,3=DIV,4=DIVU,5=MFHI,6=MFLO,7=MTHI,8=MTLO, others=NONE.
REQ-004 SHALL have e_rs, e_rt  in  32 each  forwarded operands.
REQ-005 SHALL have mdu_src0, mdu_src1  out  32 each  operands; mdu_op  out  2  01=MUL,10=DIV; mdu_sign  out  1  signed op.
REQ-006 SHALL have mdu_in_valid  out  1; mdu_in_ready  in  1; mdu_out_valid  in  1; mdu_out_ready  out  1; mdu_res0 (LO), mdu_res1 (HI)  in  32 each.
REQ-007 SHALL have md_stall  out  1  freeze E and earlier; md_busy  out  1  op in flight; mf_data  out  32  MFHI/MFLO result; hi, lo  out  32 each.

Function
REQ-008 SHALL implement FSM states IDLE and BUSY.
REQ-009 start = e_valid & !e_flush & e_mdop in {MULT..DIVU} & state==IDLE; mdu_in_valid SHALL equal start combinationally.
REQ-010 mdu_src0=e_rs, mdu_src1=e_rt, mdu_op=01 for MULT/MULTU else 10, mdu_sign=1 for MULT/DIV; all SHALL be held while mdu_in_valid is asserted.
REQ-011 IDLE->BUSY SHALL occur on start & mdu_in_ready; start & !mdu_in_ready SHALL stay IDLE with md_stall=1.
REQ-012 mdu_out_ready SHALL be 1 exactly when state==BUSY.
REQ-013 BUSY->IDLE SHALL occur on mdu_out_valid & mdu_out_ready, writing lo<=mdu_res0, hi<=mdu_res1 at that edge.
REQ-014 md_stall SHALL be 1 when e_valid & !e_flush & e_mdop!=NONE & (state==BUSY | (start & !mdu_in_ready)); accepted MULT/DIV itself SHALL NOT stall.
REQ-015 In BUSY, an MD op in E SHALL stall even in the completion cycle; it proceeds the following cycle (IDLE).
REQ-016 MTHI/MTLO SHALL write hi/lo <= e_rs at the edge when e_valid & !e_flush & !md_stall.
REQ-017 mf_data SHALL be hi for MFHI, lo otherwise; purely combinational from registers.
REQ-018 e_flush SHALL suppress start and MTHI/MTLO writes; it SHALL NOT cancel an op already in BUSY.
REQ-019 md_busy SHALL equal (state==BUSY).
REQ-020 mdu_out_valid observed in IDLE SHALL be ignored (no hi/lo write).

Reset
REQ-021 On reset edge: state=IDLE, hi=0, lo=0; hence md_busy=0, mdu_out_ready=0.
REQ-022 Reset during BUSY SHALL abandon the op; no later hi/lo write from it (unit reset alongside).
REQ-023 While reset is high, mdu_in_valid and md_stall SHALL be 0.

Configuration
REQ-024 Macro MD_DIV0_SKIP_EN: when defined, DIV/DIVU with e_rt==0 SHALL NOT assert mdu_in_valid, SHALL NOT stall, and SHALL leave hi/lo unchanged, state IDLE.
REQ-025 Without MD_DIV0_SKIP_EN, divide-by-zero SHALL issue normally and write whatever the unit returns.

Verification
REQ-026 MULT rs=0xFFFFFFFE, rt=3, ready=1, unit returns after 5 cycles -> 1 cycle md_busy rising, hi=0xFFFFFFFF, lo=0xFFFFFFFA, md_stall=0 throughout.
REQ-027 DIVU 7/2 then MFLO next cycle -> md_stall=1 until completion+1, then mf_data=3; MFHI gives 1.
REQ-028 MULT with mdu_in_ready=0 for 3 cycles -> md_stall=1, mdu_in_valid=1, operands stable 3 cycles, then accept.
REQ-029 MTHI 0x12345678 with e_flush=1 -> hi unchanged; same with e_flush=0 -> hi=0x12345678.
REQ-030 Reset asserted in BUSY, then mdu_out_valid=1 -> hi=lo=0, state IDLE, no write.
REQ-031 DIV rt=0, hi=lo=0xA5A5A5A5 -> with MD_DIV0_SKIP_EN no mdu_in_valid, hi/lo unchanged; without it, mdu_in_valid=1 and BUSY entered.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_if -- handshake bundle between the multiply/divide issue
// controller and the multiply/divide execution unit.
//
// Signals:
//   mdu_src0, mdu_src1  operands presented to the unit
//   mdu_op              01 = multiply, 10 = divide
//   mdu_sign            1 = signed operation
//   mdu_in_valid        request valid          (controller -> unit)
//   mdu_in_ready        unit accepts request   (unit -> controller)
//   mdu_out_valid       result valid           (unit -> controller)
//   mdu_out_ready       controller takes result (controller -> unit)
//   mdu_res0, mdu_res1  result LO / HI
//
// Modports: master = issue controller, slave = execution unit.
// ---------------------------------------------------------------------------
interface md_issue_ctrl_if;
   logic [31:0] mdu_src0;
   logic [31:0] mdu_src1;
   logic [1:0]  mdu_op;
   logic        mdu_sign;
   logic        mdu_in_valid;
   logic        mdu_in_ready;
   logic        mdu_out_valid;
   logic        mdu_out_ready;
   logic [31:0] mdu_res0;
   logic [31:0] mdu_res1;

   modport master (
      output mdu_src0, mdu_src1, mdu_op, mdu_sign, mdu_in_valid, mdu_out_ready,
      input  mdu_in_ready, mdu_out_valid, mdu_res0, mdu_res1
   );

   modport slave (
      input  mdu_src0, mdu_src1, mdu_op, mdu_sign, mdu_in_valid, mdu_out_ready,
      output mdu_in_ready, mdu_out_valid, mdu_res0, mdu_res1
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl -- issues MULT/MULTU/DIV/DIVU from the E stage to a
// multi-cycle multiply/divide unit, owns the HI/LO registers, serves
// MFHI/MFLO/MTHI/MTLO, and stalls E (and earlier) while an op is in flight.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   e_valid, e_flush  E-stage instruction valid / cancelled this cycle
//   e_mdop            0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,
//                     7 MTHI,8 MTLO, others NONE
//   e_rs, e_rt        forwarded operands
//   mdu               md_issue_ctrl_if.master, handshake to the unit
//   md_stall          freeze E and earlier
//   md_busy           an op is in flight
//   mf_data           MFHI/MFLO read data
//   hi, lo            architectural HI/LO
//
// Configuration:
//   MD_DIV0_SKIP_EN   when defined, DIV/DIVU with e_rt == 0 is not issued,
//                     does not stall and leaves HI/LO unchanged.
// ---------------------------------------------------------------------------
module md_issue_ctrl (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  e_valid,
   input  logic                  e_flush,
   input  logic [3:0]            e_mdop,
   input  logic [31:0]           e_rs,
   input  logic [31:0]           e_rt,
   md_issue_ctrl_if.master       mdu,
   output logic                  md_stall,
   output logic                  md_busy,
   output logic [31:0]           mf_data,
   output logic [31:0]           hi,
   output logic [31:0]           lo
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   state_e state_q;
   state_e state_d;

   logic e_live;
   logic is_mul;
   logic is_div;
   logic is_md_op;
   logic div0_skip;
   logic start;
   logic complete;
   logic mt_write;

   // Instruction decode; codes 9..15 decode as NONE.
   assign is_mul   = (e_mdop == OP_MULT) || (e_mdop == OP_MULTU);
   assign is_div   = (e_mdop == OP_DIV)  || (e_mdop == OP_DIVU);
   assign is_md_op = (e_mdop >= OP_MULT) && (e_mdop <= OP_MTLO);

   // Reset gating keeps mdu_in_valid and md_stall low while reset is held.
   assign e_live   = !reset && e_valid && !e_flush;

`ifdef MD_DIV0_SKIP_EN
   assign div0_skip = is_div && (e_rt == 32'd0);
`else
   assign div0_skip = 1'b0;
`endif

   // Operands are taken straight from E; E is frozen by md_stall while the
   // request waits for mdu_in_ready, so they hold without extra registers.
   assign mdu.mdu_src0 = e_rs;
   assign mdu.mdu_src1 = e_rt;
   assign mdu.mdu_op   = is_mul ? 2'b01 : 2'b10;
   assign mdu.mdu_sign = (e_mdop == OP_MULT) || (e_mdop == OP_DIV);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d           = state_q;
      start             = 1'b0;
      complete          = 1'b0;
      md_stall          = 1'b0;
      mdu.mdu_in_valid  = 1'b0;
      mdu.mdu_out_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            start            = e_live && (is_mul || is_div) && !div0_skip;
            mdu.mdu_in_valid = start;
            // Only a request the unit refuses holds E back; an accepted
            // MULT/DIV leaves E this cycle.
            md_stall         = start && !mdu.mdu_in_ready;
            if (start && mdu.mdu_in_ready) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            mdu.mdu_out_ready = 1'b1;
            // Any MD op waits, even in the completion cycle, so it sees the
            // HI/LO written at this edge when it proceeds next cycle.
            md_stall          = e_live && is_md_op;
            complete          = mdu.mdu_out_valid;
            if (mdu.mdu_out_valid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mt_write = e_live && !md_stall;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Unit results take priority; an MTHI/MTLO cannot coincide with a
   // completion because it is stalled while BUSY.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (complete) begin
         lo <= mdu.mdu_res0;
         hi <= mdu.mdu_res1;
      end else if (mt_write && (e_mdop == OP_MTHI)) begin
         hi <= e_rs;
      end else if (mt_write && (e_mdop == OP_MTLO)) begin
         lo <= e_rs;
      end
   end

   assign md_busy = (state_q == S_BUSY);
   assign mf_data = (e_mdop == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl -- self-checking bench for md_issue_ctrl. A transaction-
// level model (busy flag, HI/LO values, a behavioural unit that computes
// results with plain arithmetic after a random latency) predicts every
// output each cycle; directed sequences cover the named scenarios, then a
// randomized run follows.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        e_valid;
   logic        e_flush;
   logic [3:0]  e_mdop;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        md_stall;
   logic        md_busy;
   logic [31:0] mf_data;
   logic [31:0] hi;
   logic [31:0] lo;

   md_issue_ctrl_if mdu_if ();

   md_issue_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .e_valid  (e_valid),
      .e_flush  (e_flush),
      .e_mdop   (e_mdop),
      .e_rs     (e_rs),
      .e_rt     (e_rt),
      .mdu      (mdu_if.master),
      .md_stall (md_stall),
      .md_busy  (md_busy),
      .mf_data  (mf_data),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   bit          m_busy;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          u_cnt;
   logic [31:0] u_res0;
   logic [31:0] u_res1;
   int          fixed_lat = -1;

   // Behavioural unit: LO = product low / quotient, HI = product high /
   // remainder. Divide by zero returns an arbitrary but known pattern.
   task automatic mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r0, output logic [31:0] r1);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = 64'(sa * sb); r0 = p[31:0]; r1 = p[63:32]; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; r0 = p[31:0]; r1 = p[63:32]; end
         default: begin
            if (b == 32'd0) begin
               r0 = a ^ 32'h5A5A5A5A;
               r1 = 32'hDEADBEEF;
            end else if (op == 4'd3) begin
               q = sa / sb; r = sa % sb;
               p = 64'(q); r0 = p[31:0];
               p = 64'(r); r1 = p[31:0];
            end else begin
               r0 = a / b;
               r1 = a % b;
            end
         end
      endcase
   endtask

   // One clock cycle: drive at negedge, check combinational/registered
   // outputs against the model, then advance the model across the posedge.
   task automatic step(input bit rst, input bit ev, input bit ef, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input bit rdy, input bit spur);
      bit          is_mul;
      bit          is_div;
      bit          is_md;
      bit          live;
      bit          skip;
      bit          x_iv;
      bit          x_stall;
      bit          ov;
      logic [31:0] r0;
      logic [31:0] r1;
      @(negedge clk);
      reset   = rst;
      e_valid = ev;
      e_flush = ef;
      e_mdop  = op;
      e_rs    = rs;
      e_rt    = rt;
      mdu_if.mdu_in_ready = rdy;
      ov = m_busy ? (u_cnt == 0) : spur;
      mdu_if.mdu_out_valid = ov;
      if (m_busy && u_cnt == 0) begin
         mdu_if.mdu_res0 = u_res0;
         mdu_if.mdu_res1 = u_res1;
      end else begin
         mdu_if.mdu_res0 = $urandom;
         mdu_if.mdu_res1 = $urandom;
      end
      #1;
      is_mul = (op == 4'd1) || (op == 4'd2);
      is_div = (op == 4'd3) || (op == 4'd4);
      is_md  = (op >= 4'd1) && (op <= 4'd8);
      live   = !rst && ev && !ef;
      skip   = 1'b0;
`ifdef MD_DIV0_SKIP_EN
      skip   = is_div && (rt == 32'd0);
`endif
      x_iv    = live && (is_mul || is_div) && !skip && !m_busy;
      x_stall = live && is_md && (m_busy || (x_iv && !rdy));

      check("in_valid",  32'(mdu_if.mdu_in_valid),  32'(x_iv));
      check("stall",     32'(md_stall),             32'(x_stall));
      check("busy",      32'(md_busy),              32'(m_busy));
      check("out_ready", 32'(mdu_if.mdu_out_ready), 32'(m_busy));
      check("hi",        hi, m_hi);
      check("lo",        lo, m_lo);
      check("mf_data",   mf_data, (op == 4'd5) ? m_hi : m_lo);
      if (x_iv) begin
         check("src0", mdu_if.mdu_src0, rs);
         check("src1", mdu_if.mdu_src1, rt);
         check("op",   32'(mdu_if.mdu_op), is_mul ? 32'd1 : 32'd2);
         check("sign", 32'(mdu_if.mdu_sign), 32'((op == 4'd1) || (op == 4'd3)));
      end

      if (rst) begin
         m_busy = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (m_busy) begin
         if (ov) begin
            m_hi   = u_res1;
            m_lo   = u_res0;
            m_busy = 1'b0;
         end else begin
            u_cnt--;
         end
      end else if (x_iv && rdy) begin
         mdu_calc(op, rs, rt, r0, r1);
         u_res0 = r0;
         u_res1 = r1;
         m_busy = 1'b1;
         u_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      end else if (live && !x_stall && op == 4'd7) begin
         m_hi = rs;
      end else if (live && !x_stall && op == 4'd8) begin
         m_lo = rs;
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [31:0] hi_before;
      bit          saw_busy;
      reset   = 1'b1;
      e_valid = 1'b0;
      e_flush = 1'b0;
      e_mdop  = 4'd0;
      e_rs    = '0;
      e_rt    = '0;
      mdu_if.mdu_in_ready  = 1'b0;
      mdu_if.mdu_out_valid = 1'b0;
      mdu_if.mdu_res0      = '0;
      mdu_if.mdu_res1      = '0;
      m_busy = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      u_cnt  = 0;
      repeat (2) @(posedge clk);

      // Reset state, with an MD op presented while reset is held.
      step(1'b1, 1'b1, 1'b0, 4'd1, 32'd5, 32'd6, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Signed MULT -2 * 3, unit answers 5 cycles after accept.
      fixed_lat = 4;
      step(1'b0, 1'b1, 1'b0, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
      check("r026_busy_rise", 32'(md_busy), 32'd0);
      idle_steps(1);
      check("r026_busy_on", 32'(md_busy), 32'd1);
      idle_steps(6);
      check("r026_hi", hi, 32'hFFFFFFFF);
      check("r026_lo", lo, 32'hFFFFFFFA);

      // DIVU 7/2 followed by MFLO held in E until it is released.
      step(1'b0, 1'b1, 1'b0, 4'd4, 32'd7, 32'd2, 1'b1, 1'b0);
      repeat (7) step(1'b0, 1'b1, 1'b0, 4'd6, 32'd0, 32'd0, 1'b1, 1'b0);
      check("r027_mflo", mf_data, 32'd3);
      step(1'b0, 1'b1, 1'b0, 4'd5, 32'd0, 32'd0, 1'b1, 1'b0);
      check("r027_mfhi", mf_data, 32'd1);

      // MULTU refused by the unit for 3 cycles, then accepted.
      fixed_lat = 2;
      repeat (3) step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b0);
      idle_steps(5);
      check("r028_hi", hi, 32'd3);
      check("r028_lo", lo, 32'd0);

      // MTHI flushed, then not flushed.
      hi_before = m_hi;
      step(1'b0, 1'b1, 1'b1, 4'd7, 32'h12345678, 32'd0, 1'b1, 1'b0);
      idle_steps(1);
      check("r029_flush_hi", hi, hi_before);
      step(1'b0, 1'b1, 1'b0, 4'd7, 32'h12345678, 32'd0, 1'b1, 1'b0);
      idle_steps(1);
      check("r029_hi", hi, 32'h12345678);

      // Reset while BUSY, then a stray out_valid must not write.
      fixed_lat = 3;
      step(1'b0, 1'b1, 1'b0, 4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
      idle_steps(1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      check("r030_hi", hi, 32'd0);
      check("r030_lo", lo, 32'd0);
      check("r030_busy", 32'(md_busy), 32'd0);

      // DIV by zero with HI/LO preset.
      step(1'b0, 1'b1, 1'b0, 4'd7, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd8, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd3, 32'd77, 32'd0, 1'b1, 1'b0);
      saw_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         idle_steps(1);
         if (md_busy) saw_busy = 1'b1;
      end
`ifdef MD_DIV0_SKIP_EN
      check("r031_busy", 32'(saw_busy), 32'd0);
      check("r031_hi", hi, 32'hA5A5A5A5);
`else
      check("r031_busy", 32'(saw_busy), 32'd1);
      check("r031_hi", hi, 32'hDEADBEEF);
`endif

      // Randomized traffic.
      fixed_lat = -1;
      for (int i = 0; i < 3000; i++) begin
         bit          r_rst;
         logic [3:0]  r_op;
         logic [31:0] r_rt;
         r_rst = ($urandom_range(0, 99) == 0);
         r_op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
         r_rt  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         step(r_rst, ($urandom_range(0, 4) != 0), ($urandom_range(0, 6) == 0), r_op,
              32'($urandom), r_rt, ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
